// File: rtl/motor_pkg.sv
// Shared state encodings, channel indices and target field positions
// for the two-channel motor ramp sequencer.
package motor_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DWELL = 2'd2;
   localparam state_t ST_ESTOP = 2'd3;

   localparam int LEFT    = 0;
   localparam int RIGHT   = 1;
   localparam int DIR_BIT = 7;
   localparam int MAG_MSB = 6;

   function automatic logic is_active(input state_t s);
      return (s == ST_RUN) || (s == ST_DWELL);
   endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: slew-limited duty ramp, dead-time dwell before a
// direction flip, and latched emergency stop.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | channel off, duty 0, waiting for chan_enable
// ST_RUN   | driving; duty slews toward target magnitude on each tick
// ST_DWELL | duty held at 0 for the dead time before dir may flip
// ST_ESTOP | latched stop; cleared only once chan_enable is seen low
module motor_ramp_chan
   import motor_pkg::*;
#(
   parameter int STEP           = 1,
   parameter int MAX_DUTY       = 100,
   parameter int DEADTIME_TICKS = 10
) (
   input  logic       hba_clk,
   input  logic       hba_reset,
   input  logic       tick,
   input  logic       estop,
   input  logic       chan_enable,
   input  logic [7:0] target,
   output logic       en,
   output logic       dir,
   output logic [6:0] duty,
   output logic       busy,
   output logic       estopped
);

   localparam int DW = $clog2(DEADTIME_TICKS + 1);
   localparam logic [6:0]    MAX7  = 7'(MAX_DUTY);
   localparam logic [6:0]    STEP7 = 7'(STEP);
   localparam logic [7:0]    STEP8 = 8'(STEP);
   localparam logic [DW-1:0] DEAD  = DW'(DEADTIME_TICKS);

   state_t        state_q, state_d;
   logic [6:0]    duty_q, duty_d;
   logic          dir_q, dir_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [6:0]    mag;
   logic          tdir;
   logic [7:0]    gap_up, gap_dn;

   assign tdir = target[DIR_BIT];
   assign mag  = (target[MAG_MSB:0] > MAX7) ? MAX7 : target[MAG_MSB:0];

   // Differences are taken 8 bits wide so an under-range subtraction can't wrap
   assign gap_up = {1'b0, mag} - {1'b0, duty_q};
   assign gap_dn = {1'b0, duty_q} - {1'b0, mag};

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      dwell_d = dwell_q;
      if (state_q == ST_ESTOP) begin
         if (!chan_enable) state_d = ST_IDLE;
      end else if (estop) begin
         state_d = ST_ESTOP;
         duty_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               duty_d = '0;
               if (chan_enable) begin
                  state_d = ST_RUN;
                  dir_d   = tdir;
               end
            end
            ST_RUN: begin
               if (!chan_enable) begin
                  state_d = ST_IDLE;
                  duty_d  = '0;
               end else if (tick) begin
                  if (tdir == dir_q) begin
                     if (duty_q < mag)
                        duty_d = (gap_up < STEP8) ? mag : duty_q + STEP7;
                     else if (duty_q > mag)
                        duty_d = (gap_dn < STEP8) ? mag : duty_q - STEP7;
                  end else if (duty_q != 7'd0) begin
                     duty_d = (duty_q < STEP7) ? 7'd0 : duty_q - STEP7;
                  end else begin
                     state_d = ST_DWELL;
                     dwell_d = DEAD;
                  end
               end
            end
            ST_DWELL: begin
               duty_d = '0;
               if (!chan_enable) begin
                  state_d = ST_IDLE;
               end else if (tdir == dir_q) begin
                  state_d = ST_RUN;
               end else if (tick) begin
                  dwell_d = dwell_q - DW'(1);
                  if (dwell_q == DW'(1)) begin
                     dir_d   = tdir;
                     state_d = ST_RUN;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge hba_clk or posedge hba_reset) begin
      if (hba_reset) begin
         state_q  <= ST_IDLE;
         duty_q   <= '0;
         dir_q    <= 1'b0;
         dwell_q  <= '0;
         en       <= 1'b0;
         busy     <= 1'b0;
         estopped <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         dir_q    <= dir_d;
         dwell_q  <= dwell_d;
         en       <= is_active(state_d);
         busy     <= is_active(state_d) && ((duty_d != mag) || (dir_d != tdir));
         estopped <= (state_d == ST_ESTOP);
      end
   end

   assign duty = duty_q;
   assign dir  = dir_q;

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Two-channel motor slew/direction sequencer: shared ramp tick divider
// feeding one ramp channel per motor.
module motor_ramp_ctrl
   import motor_pkg::*;
#(
   parameter int CLK_FREQUENCY  = 60_000_000,
   parameter int RAMP_TICK_HZ   = 1_000,
   parameter int STEP           = 1,
   parameter int MAX_DUTY       = 100,
   parameter int DEADTIME_TICKS = 10
) (
   input  logic       hba_clk,
   input  logic       hba_reset,
   input  logic [1:0] chan_enable,
   input  logic [7:0] target_left,
   input  logic [7:0] target_right,
   input  logic       estop,
   output logic [1:0] en,
   output logic [1:0] dir,
   output logic [6:0] duty_left,
   output logic [6:0] duty_right,
   output logic [1:0] busy,
   output logic [1:0] estopped
);

   localparam int TICK_DIV = CLK_FREQUENCY / RAMP_TICK_HZ;
   localparam int TW       = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt;
   logic          tick;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge hba_clk or posedge hba_reset) begin
      if (hba_reset)  tick_cnt <= '0;
      else if (tick)  tick_cnt <= '0;
      else            tick_cnt <= tick_cnt + TW'(1);
   end

   motor_ramp_chan #(
      .STEP(STEP), .MAX_DUTY(MAX_DUTY), .DEADTIME_TICKS(DEADTIME_TICKS)
   ) u_left (
      .hba_clk    (hba_clk),
      .hba_reset  (hba_reset),
      .tick       (tick),
      .estop      (estop),
      .chan_enable(chan_enable[LEFT]),
      .target     (target_left),
      .en         (en[LEFT]),
      .dir        (dir[LEFT]),
      .duty       (duty_left),
      .busy       (busy[LEFT]),
      .estopped   (estopped[LEFT])
   );

   motor_ramp_chan #(
      .STEP(STEP), .MAX_DUTY(MAX_DUTY), .DEADTIME_TICKS(DEADTIME_TICKS)
   ) u_right (
      .hba_clk    (hba_clk),
      .hba_reset  (hba_reset),
      .tick       (tick),
      .estop      (estop),
      .chan_enable(chan_enable[RIGHT]),
      .target     (target_right),
      .en         (en[RIGHT]),
      .dir        (dir[RIGHT]),
      .duty       (duty_right),
      .busy       (busy[RIGHT]),
      .estopped   (estopped[RIGHT])
   );

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: per-cycle comparison against a behavioural
// model plus directed literal checks of ramp, reversal, clamp, estop, reset.
module tb_motor_ramp_ctrl;

   localparam int TDIV = 10;
   localparam int STP  = 10;
   localparam int MAXD = 100;
   localparam int DEAD = 2;

   localparam int M_OFF  = 0;
   localparam int M_ON   = 1;
   localparam int M_WAIT = 2;
   localparam int M_STOP = 3;

   logic       hba_clk = 0;
   logic       hba_reset = 1;
   logic [1:0] chan_enable = 0;
   logic [7:0] target_left = 0;
   logic [7:0] target_right = 0;
   logic       estop = 0;
   logic [1:0] en, dir, busy, estopped;
   logic [6:0] duty_left, duty_right;

   int errors = 0;
   int checks = 0;

   motor_ramp_ctrl #(
      .CLK_FREQUENCY(1000), .RAMP_TICK_HZ(100), .STEP(STP),
      .MAX_DUTY(MAXD), .DEADTIME_TICKS(DEAD)
   ) dut (
      .hba_clk(hba_clk), .hba_reset(hba_reset), .chan_enable(chan_enable),
      .target_left(target_left), .target_right(target_right), .estop(estop),
      .en(en), .dir(dir), .duty_left(duty_left), .duty_right(duty_right),
      .busy(busy), .estopped(estopped)
   );

   always #5 hba_clk = ~hba_clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: plain integer per-channel bookkeeping
   int m_mode[2], m_duty[2], m_dir[2], m_wait[2], m_busy[2];
   int m_tc;

   always @(posedge hba_clk or posedge hba_reset) begin
      if (hba_reset) begin
         m_tc = 0;
         for (int c = 0; c < 2; c++) begin
            m_mode[c] = M_OFF; m_duty[c] = 0; m_dir[c] = 0; m_wait[c] = 0; m_busy[c] = 0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            logic [7:0] t;
            int mag, tdir;
            bit on, tk;
            t    = (c == 0) ? target_left : target_right;
            tdir = t[7];
            mag  = t[6:0];
            if (mag > MAXD) mag = MAXD;
            on   = chan_enable[c];
            tk   = (m_tc == TDIV - 1);
            if (m_mode[c] == M_STOP) begin
               if (!on) m_mode[c] = M_OFF;
            end else if (estop) begin
               m_mode[c] = M_STOP; m_duty[c] = 0;
            end else if (m_mode[c] == M_OFF) begin
               if (on) begin m_mode[c] = M_ON; m_dir[c] = tdir; end
            end else if (!on) begin
               m_mode[c] = M_OFF; m_duty[c] = 0;
            end else if (m_mode[c] == M_ON) begin
               if (tk) begin
                  if (tdir == m_dir[c]) begin
                     if (m_duty[c] < mag) m_duty[c] = (m_duty[c] + STP > mag) ? mag : m_duty[c] + STP;
                     else m_duty[c] = (m_duty[c] - STP < mag) ? mag : m_duty[c] - STP;
                  end else if (m_duty[c] > 0) begin
                     m_duty[c] = (m_duty[c] > STP) ? m_duty[c] - STP : 0;
                  end else begin
                     m_mode[c] = M_WAIT; m_wait[c] = DEAD;
                  end
               end
            end else begin
               if (tdir == m_dir[c]) m_mode[c] = M_ON;
               else if (tk) begin
                  m_wait[c] = m_wait[c] - 1;
                  if (m_wait[c] == 0) begin m_dir[c] = tdir; m_mode[c] = M_ON; end
               end
            end
            m_busy[c] = ((m_mode[c] == M_ON || m_mode[c] == M_WAIT) &&
                         (m_duty[c] != mag || m_dir[c] != tdir)) ? 1 : 0;
         end
         m_tc = (m_tc + 1) % TDIV;
      end
   end

   always @(negedge hba_clk) begin
      if (!hba_reset) begin
         for (int c = 0; c < 2; c++) begin
            chk($sformatf("model en[%0d]", c), en[c],
                (m_mode[c] == M_ON || m_mode[c] == M_WAIT) ? 1 : 0);
            chk($sformatf("model dir[%0d]", c), dir[c], m_dir[c]);
            chk($sformatf("model busy[%0d]", c), busy[c], m_busy[c]);
            chk($sformatf("model estopped[%0d]", c), estopped[c], (m_mode[c] == M_STOP) ? 1 : 0);
         end
         chk("model duty_left", duty_left, m_duty[0]);
         chk("model duty_right", duty_right, m_duty[1]);
      end
   end

   // Advance through the next tick edge; ends at the negedge just after it
   task automatic next_tick();
      bit found = 0;
      for (int i = 0; i < 2 * TDIV; i++) begin
         if (m_tc == TDIV - 1) begin found = 1; break; end
         @(negedge hba_clk);
      end
      chk("tick found", found, 1);
      @(negedge hba_clk);
   endtask

   initial begin
      int n;
      bit found;
      #2;
      chk("reset en", en, 0);
      chk("reset duty_left", duty_left, 0);
      chk("reset busy", busy, 0);
      chk("reset estopped", estopped, 0);
      repeat (2) @(negedge hba_clk);
      hba_reset = 0;
      @(negedge hba_clk);

      // 1: ramp up
      chan_enable = 2'b01; target_left = 8'h32;
      @(negedge hba_clk);
      chk("t1 en", en, 2'b01);
      chk("t1 busy start", busy[0], 1);
      for (int k = 1; k <= 5; k++) begin
         next_tick();
         chk("t1 duty_left", duty_left, 10 * k);
         chk("t1 duty_right", duty_right, 0);
      end
      chk("t1 busy done", busy[0], 0);

      // 2: reversal through dwell
      target_left = 8'hB2;
      for (int k = 4; k >= 0; k--) begin
         next_tick();
         chk("t2 ramp down", duty_left, 10 * k);
         chk("t2 dir held", dir[0], 0);
      end
      next_tick();
      chk("t2 dwell duty", duty_left, 0);
      chk("t2 dwell dir", dir[0], 0);
      chk("t2 dwell en", en[0], 1);
      next_tick();
      chk("t2 dwell dir 2", dir[0], 0);
      next_tick();
      chk("t2 flipped dir", dir[0], 1);
      chk("t2 flip duty", duty_left, 0);
      for (int k = 1; k <= 5; k++) begin
         next_tick();
         chk("t2 ramp up", duty_left, 10 * k);
      end

      // 3: clamp and partial step
      chan_enable = 2'b00;
      @(negedge hba_clk);
      chk("t3 off en", en[0], 0);
      chk("t3 off duty", duty_left, 0);
      target_left = 8'h7F; chan_enable = 2'b01;
      @(negedge hba_clk);
      chk("t3 dir fwd", dir[0], 0);
      for (int k = 1; k <= 10; k++) begin
         next_tick();
         chk("t3 ramp", duty_left, 10 * k);
      end
      next_tick();
      chk("t3 clamp", duty_left, 100);
      chk("t3 clamp busy", busy[0], 0);
      target_left = 8'h19;
      for (int k = 9; k >= 3; k--) begin
         next_tick();
         chk("t3 down", duty_left, 10 * k);
      end
      next_tick();
      chk("t3 partial", duty_left, 25);
      next_tick();
      chk("t3 settle", duty_left, 25);
      chk("t3 settle busy", busy[0], 0);

      // 4: estop mid-ramp
      chan_enable = 2'b00;
      @(negedge hba_clk);
      chan_enable = 2'b11; target_left = 8'h32; target_right = 8'h3C;
      @(negedge hba_clk);
      repeat (3) next_tick();
      chk("t4 pre duty_left", duty_left, 30);
      chk("t4 pre duty_right", duty_right, 30);
      estop = 1;
      @(negedge hba_clk);
      estop = 0;
      chk("t4 duty_left", duty_left, 0);
      chk("t4 duty_right", duty_right, 0);
      chk("t4 en", en, 0);
      chk("t4 estopped", estopped, 2'b11);
      repeat (15) @(negedge hba_clk);
      chk("t4 held", estopped, 2'b11);
      chan_enable = 2'b00;
      @(negedge hba_clk);
      chk("t4 cleared", estopped, 0);
      chan_enable = 2'b11;
      @(negedge hba_clk);
      chk("t4 restart en", en, 2'b11);
      next_tick();
      chk("t4 restart duty", duty_left, 10);

      // 5: estop coincides with dwell expiry
      target_left = 8'h8A;
      found = 0;
      for (int i = 0; i < 80; i++) begin
         if (m_mode[0] == M_WAIT && m_wait[0] == 1 && m_tc == TDIV - 1) begin
            found = 1; break;
         end
         @(negedge hba_clk);
      end
      chk("t5 reached dwell end", found, 1);
      estop = 1;
      @(negedge hba_clk);
      estop = 0;
      chk("t5 dir not flipped", dir[0], 0);
      chk("t5 estopped", estopped[0], 1);
      chk("t5 en", en[0], 0);

      // 6: async reset mid-period
      chan_enable = 2'b00;
      @(negedge hba_clk);
      target_left = 8'h3C; chan_enable = 2'b01;
      @(negedge hba_clk);
      repeat (6) next_tick();
      chk("t6 pre duty", duty_left, 60);
      repeat (3) @(negedge hba_clk);
      #2 hba_reset = 1;
      #1;
      chk("t6 async duty", duty_left, 0);
      chk("t6 async en", en, 0);
      chk("t6 async dir", dir, 0);
      chk("t6 async busy", busy, 0);
      @(negedge hba_clk);
      hba_reset = 0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge hba_clk);
         if (duty_left == 7'd10) begin n = i; break; end
      end
      chk("t6 first tick cycles", n, 10);

      repeat (3) @(negedge hba_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
